// File: rtl/scsi_seq_pkg.sv
// Shared FSM state encoding, host register map and status bit positions for the SCSI latch sequencer.
package scsi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    H2T_LATCH,
    T2H_LATCH,
    T2H_READY,
    ACK,
    ACK_DONE
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_SELECT = 2'd2;
  localparam logic [1:0] ADDR_IRQEN  = 2'd3;

  localparam int unsigned ST_CD      = 7;
  localparam int unsigned ST_IO      = 6;
  localparam int unsigned ST_REQ     = 5;
  localparam int unsigned ST_IRQ     = 4;
  localparam int unsigned ST_TIMEOUT = 3;
  localparam int unsigned ST_BSY     = 1;
  localparam int unsigned ST_MSG     = 0;

endpackage

// File: rtl/scsi_latch_sequencer_sync_bit.sv
// Single-bit synchroniser: STAGES flops with a configurable reset value.
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= {STAGES{RESET_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/scsi_latch_sequencer.sv
// Latch/handshake sequencer between BBC host bus and SCSI target emulator.
// Optional ACK watchdog enabled by defining BUS_TIMEOUT_EN (adds ACK_TIMEOUT parameter).
module scsi_latch_sequencer
  import scsi_seq_pkg::*;
#(
  parameter int unsigned LE_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT = 255
`endif
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       host_wr,
  input  logic       host_rd,
  input  logic [1:0] host_addr,
  input  logic       host_din0,
  input  logic       t_nreq,
  input  logic       t_io,
  input  logic       t_cd,
  input  logic       t_msg,
  input  logic       t_nbsy,
  output logic       le_h2t,
  output logic       le_t2h,
  output logic       nack,
  output logic       nsel,
  output logic [7:0] status,
  output logic       irq
);

  localparam logic [3:0] LE_LAST = 4'(LE_WIDTH - 1);

  logic nreq_s, nbsy_s, io, cd, msg;
  logic req, bsy;
  logic irq_en, timeout;
  logic [3:0] cnt;
  state_t state;

  // Active-low target lines reset high so req/bsy come out of reset inactive.
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_req (.clk(CLK), .rst_n(nRESET), .d(t_nreq), .q(nreq_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_io  (.clk(CLK), .rst_n(nRESET), .d(t_io),   .q(io));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cd  (.clk(CLK), .rst_n(nRESET), .d(t_cd),   .q(cd));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_msg (.clk(CLK), .rst_n(nRESET), .d(t_msg),  .q(msg));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bsy (.clk(CLK), .rst_n(nRESET), .d(t_nbsy), .q(nbsy_s));

  assign req = ~nreq_s;
  assign bsy = ~nbsy_s;

  logic data_wr, data_rd, status_rd, select_wr, irqen_wr;
  assign data_wr   = host_wr && (host_addr == ADDR_DATA);
  assign data_rd   = host_rd && (host_addr == ADDR_DATA);
  assign status_rd = host_rd && (host_addr == ADDR_STATUS);
  assign select_wr = host_wr && (host_addr == ADDR_SELECT);
  assign irqen_wr  = host_wr && (host_addr == ADDR_IRQEN);

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] tcnt;
`else
  logic unused_status_rd;
  assign unused_status_rd = status_rd;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state  <= IDLE;
      le_h2t <= 1'b0;
      le_t2h <= 1'b0;
      nack   <= 1'b1;
      cnt    <= '0;
`ifdef BUS_TIMEOUT_EN
      tcnt    <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      // Holding the watchdog at zero outside ACK gives the clear-on-entry behaviour.
      if (state != ACK) tcnt <= '0;
      if (status_rd) timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_wr) begin
            state  <= H2T_LATCH;
            le_h2t <= 1'b1;
            cnt    <= LE_LAST;
          end else if (req && io) begin
            state  <= T2H_LATCH;
            le_t2h <= 1'b1;
            cnt    <= LE_LAST;
          end
        end
        H2T_LATCH: begin
          if (cnt == '0) begin
            le_h2t <= 1'b0;
            if (req && !io) begin
              state <= ACK;
              nack  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        T2H_LATCH: begin
          if (cnt == '0) begin
            le_t2h <= 1'b0;
            state  <= T2H_READY;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        T2H_READY: begin
          if (!req) begin
            state <= IDLE;
          end else if (data_rd) begin
            state <= ACK;
            nack  <= 1'b0;
          end
        end
        ACK: begin
          if (!req) begin
            state <= ACK_DONE;
            nack  <= 1'b1;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            state   <= ACK_DONE;
            nack    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        ACK_DONE: state <= IDLE;
        default: begin
          state  <= IDLE;
          le_h2t <= 1'b0;
          le_t2h <= 1'b0;
          nack   <= 1'b1;
        end
      endcase
    end
  end

  // Select drops once the target answers with BSY; a select write during BSY is ignored.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      nsel   <= 1'b1;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (bsy)            nsel <= 1'b1;
      else if (select_wr) nsel <= 1'b0;
      if (irqen_wr) irq_en <= host_din0;
      irq <= irq_en && req;
    end
  end

  always_comb begin
    status             = '0;
    status[ST_CD]      = cd;
    status[ST_IO]      = io;
    status[ST_REQ]     = req;
    status[ST_IRQ]     = irq;
    status[ST_TIMEOUT] = timeout;
    status[ST_BSY]     = bsy;
    status[ST_MSG]     = msg;
  end

endmodule

// File: tb/tb_scsi_latch_sequencer.sv
// Directed self-checking bench for scsi_latch_sequencer (default LE_WIDTH/SYNC_STAGES; watchdog 10 when BUS_TIMEOUT_EN).
module tb_scsi_latch_sequencer;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       host_wr = 1'b0, host_rd = 1'b0, host_din0 = 1'b0;
  logic [1:0] host_addr = 2'd0;
  logic       t_nreq = 1'b1, t_io = 1'b0, t_cd = 1'b0, t_msg = 1'b0, t_nbsy = 1'b1;
  logic       le_h2t, le_t2h, nack, nsel, irq;
  logic [7:0] status;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 CLK = ~CLK;

`ifdef BUS_TIMEOUT_EN
  scsi_latch_sequencer #(.LE_WIDTH(2), .SYNC_STAGES(2), .ACK_TIMEOUT(10)) dut (
`else
  scsi_latch_sequencer #(.LE_WIDTH(2), .SYNC_STAGES(2)) dut (
`endif
    .CLK(CLK), .nRESET(nRESET), .host_wr(host_wr), .host_rd(host_rd),
    .host_addr(host_addr), .host_din0(host_din0), .t_nreq(t_nreq), .t_io(t_io),
    .t_cd(t_cd), .t_msg(t_msg), .t_nbsy(t_nbsy), .le_h2t(le_h2t), .le_t2h(le_t2h),
    .nack(nack), .nsel(nsel), .status(status), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic d);
    host_wr = 1'b1; host_addr = a; host_din0 = d;
    step();
    host_wr = 1'b0; host_din0 = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a);
    host_rd = 1'b1; host_addr = a;
    step();
    host_rd = 1'b0;
  endtask

  int unsigned low_cnt;

  initial begin
    step(2);
    check_eq("rst_le_h2t", le_h2t, 1'b0);
    check_eq("rst_le_t2h", le_t2h, 1'b0);
    check_eq("rst_nack",   nack,   1'b1);
    check_eq("rst_nsel",   nsel,   1'b1);
    check_eq("rst_irq",    irq,    1'b0);
    check_eq("rst_status", status, 8'h00);
    nRESET = 1'b1;
    step();

    // Host-to-target byte with handshake
    t_nreq = 1'b0; t_io = 1'b0;
    step(2);
    host_write(2'd0, 1'b0);
    check_eq("h2t_le_c1", le_h2t, 1'b1);
    check_eq("h2t_nack_c1", nack, 1'b1);
    step();
    check_eq("h2t_le_c2", le_h2t, 1'b1);
    step();
    check_eq("h2t_le_off", le_h2t, 1'b0);
    check_eq("h2t_ack", nack, 1'b0);
    host_write(2'd0, 1'b0);
    check_eq("ack_drop_wr_le", le_h2t, 1'b0);
    check_eq("ack_drop_wr_nack", nack, 1'b0);
    t_nreq = 1'b1;
    step(2);
    check_eq("ack_hold_sync", nack, 1'b0);
    step();
    check_eq("ack_release", nack, 1'b1);
    step();
    check_eq("ack_done_idle", nack, 1'b1);

    // Target-to-host byte
    t_nreq = 1'b0; t_io = 1'b1;
    step(2);
    check_eq("t2h_le_pre", le_t2h, 1'b0);
    step();
    check_eq("t2h_le_c1", le_t2h, 1'b1);
    check_eq("t2h_nack_c1", nack, 1'b1);
    step();
    check_eq("t2h_le_c2", le_t2h, 1'b1);
    step();
    check_eq("t2h_le_off", le_t2h, 1'b0);
    step(3);
    check_eq("t2h_wait_nack", nack, 1'b1);
    check_eq("t2h_status", status, 8'h60);
    host_read(2'd0);
    check_eq("t2h_ack", nack, 1'b0);
    t_nreq = 1'b1;
    step(2);
    check_eq("t2h_ack_hold", nack, 1'b0);
    step();
    check_eq("t2h_ack_release", nack, 1'b1);
    step();

    // Simultaneous host write and target request: host wins
    t_nreq = 1'b0; t_io = 1'b1;
    step(2);
    host_write(2'd0, 1'b0);
    check_eq("sim_le_h2t", le_h2t, 1'b1);
    check_eq("sim_le_t2h", le_t2h, 1'b0);
    step(2);
    check_eq("sim_h2t_off", le_h2t, 1'b0);
    check_eq("sim_no_ack", nack, 1'b1);
    step();
    check_eq("sim_then_t2h", le_t2h, 1'b1);
    check_eq("sim_then_h2t", le_h2t, 1'b0);
    step(2);
    check_eq("sim_t2h_off", le_t2h, 1'b0);
    t_nreq = 1'b1;
    step(3);
    host_read(2'd0);
    check_eq("abort_rd_idle", nack, 1'b1);
    t_io = 1'b0;
    step(2);

    // Select and IRQ
    host_write(2'd3, 1'b1);
    host_write(2'd2, 1'b0);
    check_eq("sel_low", nsel, 1'b0);
    t_nbsy = 1'b0;
    step(2);
    check_eq("sel_hold_sync", nsel, 1'b0);
    step();
    check_eq("sel_release", nsel, 1'b1);
    host_write(2'd2, 1'b0);
    check_eq("sel_ignored_bsy", nsel, 1'b1);
    t_nreq = 1'b0;
    step(2);
    check_eq("irq_latency", irq, 1'b0);
    step();
    check_eq("irq_high", irq, 1'b1);
    check_eq("status_req_irq_bsy", status, 8'h32);
    host_read(2'd1);
    check_eq("status_rd_no_effect", status, 8'h32);
    t_cd = 1'b1; t_msg = 1'b1;
    step(2);
    check_eq("status_cd_msg", status, 8'hB3);
    t_cd = 1'b0; t_msg = 1'b0;
    step(2);

    // Reset in the middle of ACK
    host_write(2'd0, 1'b0);
    step(2);
    check_eq("mid_ack_low", nack, 1'b0);
    nRESET = 1'b0;
    step();
    check_eq("mid_rst_nack", nack, 1'b1);
    check_eq("mid_rst_irq", irq, 1'b0);
    check_eq("mid_rst_nsel", nsel, 1'b1);
    check_eq("mid_rst_le", {le_h2t, le_t2h}, 2'b00);
    nRESET = 1'b1;
    step(4);
    check_eq("post_rst_irq_en_clear", irq, 1'b0);
    check_eq("post_rst_idle_nack", nack, 1'b1);
    check_eq("post_rst_status", status, 8'h22);

    // ACK held by target: watchdog or indefinite wait
    host_write(2'd0, 1'b0);
    step(2);
    check_eq("wd_ack_enter", nack, 1'b0);
    low_cnt = 1;
`ifdef BUS_TIMEOUT_EN
    for (int unsigned i = 0; i < 50 && nack == 1'b0; i++) begin
      step();
      if (nack == 1'b0) low_cnt++;
    end
    check_eq("wd_ack_len", low_cnt, 10);
    check_eq("wd_timeout_set", status[3], 1'b1);
    step();
    host_read(2'd1);
    check_eq("wd_timeout_clear", status[3], 1'b0);
    check_eq("wd_idle_nack", nack, 1'b1);
`else
    for (int unsigned i = 0; i < 999; i++) begin
      step();
      if (nack == 1'b0) low_cnt++;
    end
    check_eq("ack_hold_1000", low_cnt, 1000);
    check_eq("no_timeout_bit", status[3], 1'b0);
`endif
    t_nreq = 1'b1;
    step(4);
    check_eq("final_nack", nack, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Latch enables never overlap each other or an active ACK.
  always @(negedge CLK) begin
    if (nRESET && ((le_h2t && le_t2h) || (!nack && (le_h2t || le_t2h))))
      check_eq("le_ack_exclusive", {le_h2t, le_t2h, nack}, 3'b001);
  end

endmodule

// File: doc/scsi_latch_sequencer.md
Name: scsi_latch_sequencer

Overview:
Synchronous controller that sequences the two 8-bit transparent-on-edge data latches between the BBC host bus and the SCSI target emulator. It decodes host register strobes and samples target handshake lines. It generates the latch-enable pulses, the SCSI nACK/nSEL handshake, the host status byte and the host IRQ. It sits in the CPLD top level beside the host-to-target and target-to-host latch instances.

Parameters:
LE_WIDTH, 2, cycles each latch-enable pulse stays high (range 1-15)
SYNC_STAGES, 2, flip-flop stages on each asynchronous target input (range 2-3)
ACK_TIMEOUT, 255, ACK watchdog limit in cycles; used only with BUS_TIMEOUT_EN

Ports:
CLK  in  1  system clock
nRESET  in  1  synchronous active-low reset
host_wr  in  1  single-cycle host write strobe, synchronous to CLK
host_rd  in  1  single-cycle host read strobe, synchronous to CLK
host_addr  in  2  register select: 0=data, 1=status, 2=select, 3=IRQ enable
host_din0  in  1  host data bit 0, used for the IRQ-enable write
t_nreq  in  1  target REQ, active low, asynchronous
t_io  in  1  target I/O, 1=target-to-host, asynchronous
t_cd  in  1  target C/D, asynchronous
t_msg  in  1  target MSG, asynchronous
t_nbsy  in  1  target BSY, active low, asynchronous
le_h2t  out  1  latch enable, host-to-target latch
le_t2h  out  1  latch enable, target-to-host latch
nack  out  1  SCSI ACK, active low
nsel  out  1  SCSI SEL, active low
status  out  8  host status byte
irq  out  1  host interrupt, active high

Behaviour:
- Reset: one clock, CLK. nRESET is synchronous and active-low.
- Reset values: le_h2t=0, le_t2h=0, nack=1, nsel=1, irq=0, irq_en=0, timeout=0, FSM=IDLE. status then reflects the synchronisers, which are cleared to inactive (req=0, bsy=0).
- Reset mid-operation: all outputs return to reset values on the next edge. No partial handshake survives.
- Synchronisers: every target input passes through SYNC_STAGES flops. The FSM uses only synchronised values: req, io, cd, msg, bsy.
- FSM states: IDLE, H2T_LATCH, T2H_LATCH, T2H_READY, ACK, ACK_DONE.
- IDLE:
  - host_wr at addr 0 goes to H2T_LATCH.
  - Otherwise, req && io goes to T2H_LATCH.
  - If both occur in the same cycle, host_wr wins.
- H2T_LATCH: le_h2t=1 for exactly LE_WIDTH cycles. Then go to ACK if req && !io, else IDLE (data is captured, no handshake).
- T2H_LATCH: le_t2h=1 for LE_WIDTH cycles, then T2H_READY.
- T2H_READY: host_rd at addr 0 goes to ACK. If req drops first (target abort), return to IDLE.
- ACK: nack=0 from the first cycle in the state. Leave when req is deasserted.
- ACK_DONE: nack=1 for one cycle, then IDLE. This guarantees at least one cycle of ACK high between bytes.
- Host strobes to addr 0 outside IDLE/T2H_READY are silently dropped.
- host_rd at addr 0 in IDLE has no handshake effect.
- Select register:
  - host_wr at addr 2 sets nsel=0.
  - nsel returns to 1 the cycle after bsy is seen, or on reset.
  - A write while bsy is already active is ignored.
- IRQ enable: host_wr at addr 3 loads irq_en from host_din0.
- irq = irq_en && req, registered, so one cycle of latency after sync.
- status bits: [7]=cd, [6]=io, [5]=req, [4]=irq, [3]=timeout, [2]=0, [1]=bsy, [0]=msg.
- Read of addr 1 has no side effect. The timeout bit clears on any host read of addr 1.
- le_h2t and le_t2h are never high simultaneously. nack is never low while either LE is high.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - An 8-bit cycle counter runs while in ACK.
  - On reaching ACK_TIMEOUT, the FSM forces ACK_DONE, sets status[3]=1 and returns to IDLE.
  - The counter clears on entry to ACK.
- When undefined:
  - ACK waits indefinitely for req release.
  - status[3] is tied to 0 and no counter logic exists.

Decomposition:
- Shared package scsi_seq_pkg holds:
  - the FSM state enum;
  - register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_SELECT=2, ADDR_IRQEN=3;
  - status bit index constants.
- One sub-module is natural: sync_bit, a parameterised SYNC_STAGES flop chain with reset value, instantiated five times.

Test Plan:
- Host-to-target byte: set req=1, io=0, pulse host_wr at addr 0. Expect le_h2t high exactly 2 cycles, then nack=0. Drop req; after sync, nack=1 for ≥1 cycle, FSM back to IDLE.
- Target-to-host byte: set req=1, io=1. Expect le_t2h high 2 cycles SYNC_STAGES+1 cycles later, nack still 1. Pulse host_rd at addr 0; expect nack=0 until req drops.
- Simultaneous events in IDLE: host_wr at addr 0 in the same cycle req && io becomes true. Expect le_h2t pulse, no le_t2h, return to IDLE, then a T2H sequence.
- Select and IRQ: write addr 3 with din0=1, then write addr 2. Expect nsel=0. Assert t_nbsy=0; expect nsel=1 after sync+1. With req=1, expect irq=1 and status=8'b0011_0010 when io=cd=msg=0.
- Reset mid-ACK: drive nRESET=0 for one cycle while nack=0. Expect nack=1, irq_en=0 and FSM in IDLE next cycle.
- With BUS_TIMEOUT_EN, ACK_TIMEOUT=10: hold req=1 during ACK. Expect nack to release after 10 cycles and status[3]=1; a read of addr 1 clears status[3]. Without the macro, nack stays low for 1000 cycles.
